dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter_if.sv | 43 ++++
 rtl/dma_arbiter.sv | 125 ++++++++++++
 tb/tb_dma_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dma_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_arbiter_if
//  Description : Channel-side and RAM-side signal bundle for dma_arbiter.
//                master = the two DMA channels plus the RAM sink,
//                slave  = the arbiter itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface dma_arbiter_if #(
  parameter int ADDR_W = 64
);
  // Channel 1 request side
  logic              act1_IN;
  logic              valid1_IN;
  logic              End1_IN;
  logic [ADDR_W-1:0] addr1_IN;
  // Channel 2 request side
  logic              act2_IN;
  logic              valid2_IN;
  logic              End2_IN;
  logic [ADDR_W-1:0] addr2_IN;
  // Arbiter / RAM side
  logic              gnt1_OUT;
  logic              gnt2_OUT;
  logic              valid_OUT;
  logic              End_OUT;
  logic [ADDR_W-1:0] addr_RAM;
  logic [1:0]        trans;
  logic              abort_OUT;

  modport master (
    output act1_IN, valid1_IN, End1_IN, addr1_IN,
    output act2_IN, valid2_IN, End2_IN, addr2_IN,
    input  gnt1_OUT, gnt2_OUT, valid_OUT, End_OUT, addr_RAM, trans, abort_OUT
  );

  modport slave (
    input  act1_IN, valid1_IN, End1_IN, addr1_IN,
    input  act2_IN, valid2_IN, End2_IN, addr2_IN,
    output gnt1_OUT, gnt2_OUT, valid_OUT, End_OUT, addr_RAM, trans, abort_OUT
  );
endinterface
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_arbiter
//  Description : Two-channel round-robin arbiter for a single RAM port.
//                Grants a channel per burst, forwards beats with one cycle
//                of latency, forces a yield after MAX_BEATS beats and
//                aborts a grant whose channel drops its request.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic          clk,
  input  logic          reset,
  dma_arbiter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CH1  = 2'b01,
    CH2  = 2'b10
  } state_t;

  state_t            state;
  logic              last_grant;   // 0: channel 1 was granted last, 1: channel 2
  logic [CNT_W-1:0]  beat_cnt;

  logic              sel_act;
  logic              sel_valid;
  logic              sel_end;
  logic [ADDR_W-1:0] sel_addr;
  logic [CNT_W-1:0]  next_cnt;
  logic              ends_grant;

  // Select the owning channel's inputs; the other channel is invisible while granted.
  always_comb begin
    sel_act   = bus.act1_IN;
    sel_valid = bus.valid1_IN;
    sel_end   = bus.End1_IN;
    sel_addr  = bus.addr1_IN;
    if (state == CH2) begin
      sel_act   = bus.act2_IN;
      sel_valid = bus.valid2_IN;
      sel_end   = bus.End2_IN;
      sel_addr  = bus.addr2_IN;
    end
  end

  // A natural End and the forced yield collapse into one End_OUT pulse.
  assign next_cnt   = beat_cnt + ONE_CNT;
  assign ends_grant = sel_end || (next_cnt == MAX_CNT);

  // Arbitration FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      beat_cnt      <= '0;
      bus.gnt1_OUT  <= 1'b0;
      bus.gnt2_OUT  <= 1'b0;
      bus.valid_OUT <= 1'b0;
      bus.End_OUT   <= 1'b0;
      bus.abort_OUT <= 1'b0;
      bus.addr_RAM  <= '0;
      bus.trans     <= 2'b00;
    end else begin
      bus.valid_OUT <= 1'b0;
      bus.End_OUT   <= 1'b0;
      bus.abort_OUT <= 1'b0;
      case (state)
        IDLE: begin
          // Channel 1 wins when alone, or on a tie if channel 2 went last.
          if (bus.act1_IN && (!bus.act2_IN || last_grant)) begin
            state        <= CH1;
            last_grant   <= 1'b0;
            beat_cnt     <= '0;
            bus.gnt1_OUT <= 1'b1;
            bus.trans    <= 2'b01;
          end else if (bus.act2_IN) begin
            state        <= CH2;
            last_grant   <= 1'b1;
            beat_cnt     <= '0;
            bus.gnt2_OUT <= 1'b1;
            bus.trans    <= 2'b10;
          end
        end
        CH1, CH2: begin
          if (sel_valid) begin
            bus.valid_OUT <= 1'b1;
            bus.addr_RAM  <= sel_addr;
            bus.End_OUT   <= ends_grant;
            if (ends_grant) begin
              state        <= IDLE;
              bus.gnt1_OUT <= 1'b0;
              bus.gnt2_OUT <= 1'b0;
              bus.trans    <= 2'b00;
            end else begin
              beat_cnt <= next_cnt;
            end
          end else if (!sel_act) begin
            // Owner walked away mid-grant without finishing the burst.
            state         <= IDLE;
            bus.abort_OUT <= 1'b1;
            bus.gnt1_OUT  <= 1'b0;
            bus.gnt2_OUT  <= 1'b0;
            bus.trans     <= 2'b00;
          end
        end
        default: begin
          state        <= IDLE;
          bus.gnt1_OUT <= 1'b0;
          bus.gnt2_OUT <= 1'b0;
          bus.trans    <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_arbiter
//  Description : Directed self-checking bench for dma_arbiter (MAX_BEATS=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_arbiter;

  localparam int ADDR_W = 64;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  dma_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dma_arbiter #(
    .ADDR_W    (ADDR_W),
    .MAX_BEATS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic g1, input logic g2,
                     input logic v, input logic e, input logic ab,
                     input logic [1:0] tr, input logic [ADDR_W-1:0] a);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {bus.gnt1_OUT, bus.gnt2_OUT, bus.valid_OUT, bus.End_OUT, bus.abort_OUT, bus.trans};
    exp = {g1, g2, v, e, ab, tr};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s ctl {gnt1,gnt2,valid,End,abort,trans}: observed %b expected %b", tag, obs, exp);
    end
    tests++;
    assert (bus.addr_RAM === a) else begin
      failed++;
      $error("FAIL %s addr_RAM: observed %0h expected %0h", tag, bus.addr_RAM, a);
    end
  endtask

  task automatic clear_inputs();
    bus.act1_IN = 1'b0; bus.valid1_IN = 1'b0; bus.End1_IN = 1'b0; bus.addr1_IN = '0;
    bus.act2_IN = 1'b0; bus.valid2_IN = 1'b0; bus.End2_IN = 1'b0; bus.addr2_IN = '0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk("reset", 0, 0, 0, 0, 0, 2'b00, 64'h0);
    reset = 1'b0;

    // Single channel 1 burst of three beats
    bus.act1_IN = 1'b1;
    tick(); chk("b3_grant", 1, 0, 0, 0, 0, 2'b01, 64'h0);
    bus.valid1_IN = 1'b1; bus.addr1_IN = 64'h100;
    tick(); chk("b3_beat1", 1, 0, 1, 0, 0, 2'b01, 64'h100);
    bus.addr1_IN = 64'h108;
    tick(); chk("b3_beat2", 1, 0, 1, 0, 0, 2'b01, 64'h108);
    bus.addr1_IN = 64'h110; bus.End1_IN = 1'b1;
    tick(); chk("b3_end", 0, 0, 1, 1, 0, 2'b00, 64'h110);
    clear_inputs();
    tick(); chk("b3_idle_hold", 0, 0, 0, 0, 0, 2'b00, 64'h110);

    // Round-robin alternation with both channels requesting
    reset = 1'b1;
    tick(); chk("rr_reset", 0, 0, 0, 0, 0, 2'b00, 64'h0);
    reset = 1'b0;
    bus.act1_IN = 1'b1; bus.valid1_IN = 1'b1; bus.End1_IN = 1'b1; bus.addr1_IN = 64'hA1;
    bus.act2_IN = 1'b1; bus.valid2_IN = 1'b1; bus.End2_IN = 1'b1; bus.addr2_IN = 64'hA2;
    tick(); chk("rr_g1", 1, 0, 0, 0, 0, 2'b01, 64'h0);
    tick(); chk("rr_e1", 0, 0, 1, 1, 0, 2'b00, 64'hA1);
    tick(); chk("rr_g2", 0, 1, 0, 0, 0, 2'b10, 64'hA1);
    tick(); chk("rr_e2", 0, 0, 1, 1, 0, 2'b00, 64'hA2);
    tick(); chk("rr_g1b", 1, 0, 0, 0, 0, 2'b01, 64'hA2);
    bus.act2_IN = 1'b0; bus.valid2_IN = 1'b0; bus.End2_IN = 1'b0;
    tick(); chk("rr_e1b", 0, 0, 1, 1, 0, 2'b00, 64'hA1);
    clear_inputs();
    tick(); chk("rr_idle", 0, 0, 0, 0, 0, 2'b00, 64'hA1);

    // Forced yield on channel 2 after four beats, then regrant
    bus.act2_IN = 1'b1;
    tick(); chk("fy_grant", 0, 1, 0, 0, 0, 2'b10, 64'hA1);
    bus.valid2_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr2_IN = 64'h200 + 64'(8 * i);
      tick();
      if (i == 3) chk("fy_beat4", 0, 0, 1, 1, 0, 2'b00, 64'h218);
      else        chk("fy_beat", 0, 1, 1, 0, 0, 2'b10, 64'h200 + 64'(8 * i));
    end
    bus.addr2_IN = 64'h220;
    tick(); chk("fy_regrant", 0, 1, 0, 0, 0, 2'b10, 64'h218);
    tick(); chk("fy_beat5", 0, 1, 1, 0, 0, 2'b10, 64'h220);
    bus.addr2_IN = 64'h228;
    tick(); chk("fy_beat6", 0, 1, 1, 0, 0, 2'b10, 64'h228);
    clear_inputs();
    tick(); chk("fy_abort", 0, 0, 0, 0, 1, 2'b00, 64'h228);
    tick(); chk("fy_abort_clr", 0, 0, 0, 0, 0, 2'b00, 64'h228);

    // Channel 1 drops its request after two beats
    bus.act1_IN = 1'b1;
    tick(); chk("ab_grant", 1, 0, 0, 0, 0, 2'b01, 64'h228);
    bus.valid1_IN = 1'b1; bus.addr1_IN = 64'h300;
    tick(); chk("ab_beat1", 1, 0, 1, 0, 0, 2'b01, 64'h300);
    bus.addr1_IN = 64'h308;
    tick(); chk("ab_beat2", 1, 0, 1, 0, 0, 2'b01, 64'h308);
    clear_inputs();
    tick(); chk("ab_abort", 0, 0, 0, 0, 1, 2'b00, 64'h308);
    tick(); chk("ab_after", 0, 0, 0, 0, 0, 2'b00, 64'h308);

    // Request drop coincident with an End beat is a normal end
    bus.act1_IN = 1'b1;
    tick(); chk("de_grant", 1, 0, 0, 0, 0, 2'b01, 64'h308);
    bus.act1_IN = 1'b0; bus.valid1_IN = 1'b1; bus.End1_IN = 1'b1; bus.addr1_IN = 64'h400;
    tick(); chk("de_end", 0, 0, 1, 1, 0, 2'b00, 64'h400);
    clear_inputs();
    tick(); chk("de_idle", 0, 0, 0, 0, 0, 2'b00, 64'h400);

    // Reset in the middle of a channel 1 burst
    bus.act1_IN = 1'b1;
    tick(); chk("mr_grant", 1, 0, 0, 0, 0, 2'b01, 64'h400);
    bus.valid1_IN = 1'b1; bus.addr1_IN = 64'h500;
    tick(); chk("mr_beat1", 1, 0, 1, 0, 0, 2'b01, 64'h500);
    bus.addr1_IN = 64'h508; reset = 1'b1;
    tick(); chk("mr_reset", 0, 0, 0, 0, 0, 2'b00, 64'h0);
    reset = 1'b0;
    clear_inputs();
    bus.act1_IN = 1'b1; bus.act2_IN = 1'b1;
    tick(); chk("mr_tie_ch1", 1, 0, 0, 0, 0, 2'b01, 64'h0);

    // Channel 2 traffic is ignored while channel 1 owns the port
    bus.valid2_IN = 1'b1; bus.End2_IN = 1'b1; bus.addr2_IN = 64'hDEAD;
    bus.valid1_IN = 1'b1; bus.addr1_IN = 64'h600;
    tick(); chk("ig_beat1", 1, 0, 1, 0, 0, 2'b01, 64'h600);
    bus.valid1_IN = 1'b0;
    tick(); chk("ig_wait", 1, 0, 0, 0, 0, 2'b01, 64'h600);
    bus.valid1_IN = 1'b1; bus.End1_IN = 1'b1; bus.addr1_IN = 64'h608;
    tick(); chk("ig_end", 0, 0, 1, 1, 0, 2'b00, 64'h608);
    clear_inputs();
    tick(); chk("ig_idle", 0, 0, 0, 0, 0, 2'b00, 64'h608);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
